// File: rtl/shift_req_scheduler.sv
// Round-robin scheduler sharing one right barrel shifter between requesters.
// The result is held in a single registered output slot with valid/ready.
module shift_req_scheduler #(
    parameter int DATA_WIDTH = 10,
    parameter int SA_WIDTH   = $clog2(DATA_WIDTH),
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
    input  logic [NUM_REQ*SA_WIDTH-1:0]    i_req_sa,
    input  logic [NUM_REQ-1:0]             i_req_st,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [DATA_WIDTH-1:0]          o_rsp_data,
    output logic [ID_WIDTH-1:0]            o_rsp_id
);

    logic                         rsp_valid_q;
    logic [DATA_WIDTH-1:0]        rsp_data_q;
    logic [ID_WIDTH-1:0]          rsp_id_q;
    logic [ID_WIDTH-1:0]          ptr_q;
    logic [ID_WIDTH-1:0]          ptr_d;

    logic                         slot_free;
    logic                         gnt_found;
    logic [ID_WIDTH-1:0]          gnt_id;
    logic                         accept;
    int                           scan_idx;
    int                           nxt_idx;
    int                           sel_idx;

    logic [DATA_WIDTH-1:0]        sel_data;
    logic [SA_WIDTH-1:0]          sel_sa;
    logic                         sel_st;
    logic signed [DATA_WIDTH:0]   sh_ext;
    logic signed [DATA_WIDTH:0]   sh_res;
    logic [DATA_WIDTH-1:0]        shift_result;

    assign slot_free = !rsp_valid_q || i_rsp_ready;
    assign accept    = gnt_found && slot_free;

    // Find the first valid requester starting at the priority pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!gnt_found && i_req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_WIDTH'(scan_idx);
            end
        end
    end

    // Grant is one-hot and only offered when the output slot can take it.
    always_comb begin
        o_req_ready         = '0;
        o_req_ready[gnt_id] = accept;
    end

    // Route the granted operands into the shared shifter.
    always_comb begin
        sel_idx      = int'(gnt_id);
        sel_data     = i_req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        sel_sa       = i_req_sa[sel_idx*SA_WIDTH +: SA_WIDTH];
        sel_st       = i_req_st[sel_idx];
        sh_ext       = {sel_st & sel_data[DATA_WIDTH-1], sel_data};
        sh_res       = sh_ext >>> sel_sa;
        shift_result = sh_res[DATA_WIDTH-1:0];
    end

    // Pointer moves to the requester after the one just accepted.
    always_comb begin
        nxt_idx = int'(gnt_id) + 1;
        if (nxt_idx >= NUM_REQ) begin
            nxt_idx = 0;
        end
        ptr_d = accept ? ID_WIDTH'(nxt_idx) : ptr_q;
    end

    // Output slot and arbitration pointer state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= shift_result;
                rsp_id_q    <= gnt_id;
            end else if (i_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_req_scheduler.sv
// Directed bench for shift_req_scheduler with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked away from the rising edge.
module tb_shift_req_scheduler;

    localparam int DW  = 10;
    localparam int SAW = 4;
    localparam int NR  = 2;
    localparam int IDW = 1;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_data;
    logic [NR*SAW-1:0] req_sa;
    logic [NR-1:0]     req_st;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic [IDW-1:0]    rsp_id;

    int errors = 0;
    int checks = 0;

    shift_req_scheduler #(
        .DATA_WIDTH(DW),
        .SA_WIDTH(SAW),
        .NUM_REQ(NR),
        .ID_WIDTH(IDW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_data(req_data),
        .i_req_sa(req_sa),
        .i_req_st(req_st),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data),
        .o_rsp_id(rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [DW-1:0] d,
                           input logic [SAW-1:0] sa, input logic st);
        req_data[k*DW +: DW]   = d;
        req_sa[k*SAW +: SAW]   = sa;
        req_st[k]              = st;
    endtask

    // One cycle: apply valids/ready, check grant, clock, check slot.
    task automatic step(input string tag, input logic [1:0] v, input logic rr,
                        input logic [1:0] exp_rdy, input logic exp_vld,
                        input logic [DW-1:0] exp_data, input logic exp_id);
        req_valid = v;
        rsp_ready = rr;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(rsp_valid), 32'(exp_vld));
        if (exp_vld) begin
            chk({tag, ".data"}, 32'(rsp_data), 32'(exp_data));
            chk({tag, ".id"}, 32'(rsp_id), 32'(exp_id));
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, ".data"}, 32'(rsp_data), 32'h0);
        chk({tag, ".id"}, 32'(rsp_id), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_sa    = '0;
        req_st    = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        do_reset("rst0");

        // Single requester, arithmetic then logical, sa 3 and sa past width.
        set_req(0, 10'h200, 4'd3, 1'b1);
        set_req(1, 10'h3FF, 4'd5, 1'b1);
        step("t1_asr3", 2'b01, 1'b1, 2'b01, 1'b1, 10'h3C0, 1'b0);
        set_req(0, 10'h200, 4'd3, 1'b0);
        step("t2_lsr3", 2'b01, 1'b1, 2'b01, 1'b1, 10'h040, 1'b0);
        set_req(0, 10'h200, 4'd12, 1'b1);
        step("t2_asr12", 2'b01, 1'b1, 2'b01, 1'b1, 10'h3FF, 1'b0);
        set_req(0, 10'h200, 4'd12, 1'b0);
        step("t2_lsr12", 2'b01, 1'b1, 2'b01, 1'b1, 10'h000, 1'b0);
        step("t2_drain", 2'b00, 1'b1, 2'b00, 1'b0, 10'h000, 1'b0);

        // Both requesting every cycle: strict alternation.
        do_reset("rst1");
        set_req(0, 10'h155, 4'd0, 1'b0);
        set_req(1, 10'h2AA, 4'd1, 1'b1);
        step("t3_g0", 2'b11, 1'b1, 2'b01, 1'b1, 10'h155, 1'b0);
        step("t3_g1", 2'b11, 1'b1, 2'b10, 1'b1, 10'h355, 1'b1);
        step("t3_g2", 2'b11, 1'b1, 2'b01, 1'b1, 10'h155, 1'b0);
        step("t3_g3", 2'b11, 1'b1, 2'b10, 1'b1, 10'h355, 1'b1);

        // Consumer stalls: no grants, slot contents frozen.
        step("t4_stall0", 2'b11, 1'b0, 2'b00, 1'b1, 10'h355, 1'b1);
        step("t4_stall1", 2'b11, 1'b0, 2'b00, 1'b1, 10'h355, 1'b1);
        step("t4_stall2", 2'b11, 1'b0, 2'b00, 1'b1, 10'h355, 1'b1);
        step("t4_resume", 2'b11, 1'b1, 2'b01, 1'b1, 10'h155, 1'b0);

        // Only req1 valid twice, then req0 wins after the wrap.
        step("t5_r1a", 2'b10, 1'b1, 2'b10, 1'b1, 10'h355, 1'b1);
        set_req(1, 10'h0F0, 4'd4, 1'b0);
        step("t5_r1b", 2'b10, 1'b1, 2'b10, 1'b1, 10'h00F, 1'b1);
        set_req(0, 10'h301, 4'd9, 1'b1);
        step("t5_both", 2'b11, 1'b1, 2'b01, 1'b1, 10'h3FF, 1'b0);

        // Reset while full and stalled discards the result.
        step("t6_stall", 2'b11, 1'b0, 2'b00, 1'b1, 10'h3FF, 1'b0);
        rsp_ready = 1'b0;
        do_reset("t6_rst");
        set_req(0, 10'h0AB, 4'd0, 1'b1);
        step("t6_first", 2'b11, 1'b1, 2'b01, 1'b1, 10'h0AB, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
